// File: rtl/alu_exec_pkg.sv
// Shared ALU encodings, FSM state and shift-mode types.
// Also holds WIDTH/SHAMT_W defaults shared with alucontrol.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [5:0] CTL_ADD   = 6'h01;
  localparam logic [5:0] CTL_COMP  = 6'h02;
  localparam logic [5:0] CTL_AND   = 6'h03;
  localparam logic [5:0] CTL_XOR   = 6'h04;
  localparam logic [5:0] CTL_SHLL  = 6'h05;
  localparam logic [5:0] CTL_SHRL  = 6'h06;
  localparam logic [5:0] CTL_SHRA  = 6'h07;
  localparam logic [5:0] CTL_DIFF  = 6'h08;
  localparam logic [5:0] CTL_PASSB = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } sh_mode_e;

  function automatic sh_mode_e ctl2mode(
    input logic [5:0] ctl
  );
    sh_mode_e m;
    m = SH_LL;
    unique case (1'b1)
      (ctl == CTL_SHRL): m = SH_RL;
      (ctl == CTL_SHRA): m = SH_RA;
      default:           m = SH_LL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle for alu_exec.
// master: issuer side; slave: the ALU.
interface alu_exec_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             sign;
  logic             illegal;

  modport master (
    output in_valid, control, op_a, op_b,
    output out_ready,
    input  in_ready, out_valid, result,
    input  carry, zero, sign, illegal
  );

  modport slave (
    input  in_valid, control, op_a, op_b,
    input  out_ready,
    output in_ready, out_valid, result,
    output carry, zero, sign, illegal
  );
endinterface

// File: rtl/alu_exec_shift_step.sv
// One-bit shifter: left, logical right, arithmetic right.
// Ports: i_d data in, i_mode shift kind, o_q shifted data.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_d,
  input  sh_mode_e         i_mode,
  output logic [WIDTH-1:0] o_q
);

  always_comb begin
    o_q = i_d;
    unique case (i_mode)
      SH_LL:   o_q = {i_d[WIDTH-2:0], 1'b0};
      SH_RL:   o_q = {1'b0, i_d[WIDTH-1:1]};
      SH_RA:   o_q = {i_d[WIDTH-1], i_d[WIDTH-1:1]};
      default: o_q = i_d;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU: 1-cycle ops, iterative shifts and DIFF scan.
// Ports: clk, rst (async active-low), bus (alu_exec_if.slave).
// ALU_EXEC_FAST_SHIFT_EN: shifts via barrel shifter, latency 1.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  alu_state_e       r_state, w_state_nx;
  logic [WIDTH-1:0] r_acc, w_acc_nx;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nx;
  sh_mode_e         r_mode, w_mode_nx;
  logic             r_diff, w_diff_nx;
  logic [WIDTH-1:0] r_res, w_res_nx;
  logic             r_carry, w_carry_nx;
  logic             r_ill, w_ill_nx;
  logic             r_zero, r_sign;
  logic             w_fin;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_neg;
  logic [WIDTH-1:0] w_step;
  sh_mode_e         w_step_mode;
  logic [SHAMT_W-1:0] w_amt;
  logic [5:0]       w_ctl;
  logic             w_is_sh;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_ctl    = bus.control;
  assign w_amt    = bus.op_b[SHAMT_W-1:0];
  assign w_sum    = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign w_neg    = {1'b0, ~bus.op_b} + (WIDTH+1)'(1);
  assign w_is_sh  = (w_ctl == CTL_SHLL) ||
                    (w_ctl == CTL_SHRL) ||
                    (w_ctl == CTL_SHRA);

  // DIFF scan reuses the stepper as a logical right shift
  assign w_step_mode = r_diff ? SH_RL : r_mode;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .i_d    (r_acc),
    .i_mode (w_step_mode),
    .o_q    (w_step)
  );

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_mode_nx  = r_mode;
    w_diff_nx  = r_diff;
    w_res_nx   = r_res;
    w_carry_nx = 1'b0;
    w_ill_nx   = 1'b0;
    w_fin      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_fin      = 1'b1;
          w_state_nx = S_DONE;
          unique case (1'b1)
            (w_ctl == CTL_ADD): begin
              w_res_nx   = w_sum[WIDTH-1:0];
              w_carry_nx = w_sum[WIDTH];
            end
            (w_ctl == CTL_COMP): begin
              w_res_nx   = w_neg[WIDTH-1:0];
              w_carry_nx = w_neg[WIDTH];
            end
            (w_ctl == CTL_AND):
              w_res_nx = bus.op_a & bus.op_b;
            (w_ctl == CTL_XOR):
              w_res_nx = bus.op_a ^ bus.op_b;
            (w_ctl == CTL_PASSB):
              w_res_nx = bus.op_b;
            w_is_sh: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
              unique case (ctl2mode(w_ctl))
                SH_RL:
                  w_res_nx = bus.op_a >> w_amt;
                SH_RA:
                  w_res_nx = WIDTH'(
                    $signed(bus.op_a) >>> w_amt);
                default:
                  w_res_nx = bus.op_a << w_amt;
              endcase
`else
              if (w_amt == '0) begin
                w_res_nx = bus.op_a;
              end else begin
                w_fin      = 1'b0;
                w_state_nx = S_BUSY;
                w_acc_nx   = bus.op_a;
                w_cnt_nx   = w_amt;
                w_mode_nx  = ctl2mode(w_ctl);
                w_diff_nx  = 1'b0;
              end
`endif
            end
            (w_ctl == CTL_DIFF): begin
              w_fin      = 1'b0;
              w_state_nx = S_BUSY;
              w_acc_nx   = bus.op_a ^ bus.op_b;
              w_cnt_nx   = '0;
              w_diff_nx  = 1'b1;
            end
            default: begin
              w_res_nx = '0;
              w_ill_nx = 1'b1;
            end
          endcase
        end
      end
      S_BUSY: begin
        if (r_diff) begin
          // acc holds a^b shifted down; bit 0 is bit r_cnt
          if (r_acc[0]) begin
            w_fin      = 1'b1;
            w_res_nx   = WIDTH'(r_cnt);
            w_state_nx = S_DONE;
          end else if (r_cnt == SHAMT_W'(WIDTH-1)) begin
            w_fin      = 1'b1;
            w_res_nx   = WIDTH'(WIDTH);
            w_state_nx = S_DONE;
          end else begin
            w_acc_nx = w_step;
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          w_acc_nx = w_step;
          w_cnt_nx = r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            w_fin      = 1'b1;
            w_res_nx   = w_step;
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mode  <= SH_LL;
      r_diff  <= 1'b0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_ill   <= 1'b0;
      r_zero  <= 1'b0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_mode  <= w_mode_nx;
      r_diff  <= w_diff_nx;
      if (w_fin) begin
        r_res   <= w_res_nx;
        r_carry <= w_carry_nx;
        r_ill   <= w_ill_nx;
        r_zero  <= (w_res_nx == '0);
        r_sign  <= w_res_nx[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_res;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.sign      = r_sign;
  assign bus.illegal   = r_ill;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 control  input  6  ALU control word from alucontrol, encoded per the package.
REQ-008 op_a, op_b  input  WIDTH  operands; shift amount = op_b[SHAMT_W-1:0].
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry, zero, sign  output  1 each  flags registered with result.
REQ-013 illegal  output  1  control word not decoded.

Function
REQ-014 Accept SHALL occur only on a cycle with in_valid && in_ready; inputs are captured at accept and ignored otherwise.
REQ-015 FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE->DONE on accept of ADD, COMP, AND, XOR, PASSB, illegal, or zero-amount shift; result valid the next cycle (latency 1).
REQ-017 IDLE->BUSY on accept of SHLL, SHRL or SHRA with amount n>0; each BUSY cycle shifts by one bit and decrements the count; BUSY->DONE after n cycles (latency n+1).
REQ-018 IDLE->BUSY on DIFF; scan one bit per cycle from LSB; stop at the first i where op_a[i]!=op_b[i], with result=i; if a==b, result=WIDTH after WIDTH cycles.
REQ-019 DONE->IDLE SHALL occur when out_ready=1; out_valid=1 exactly in DONE; result and flags stay stable while out_ready=0.
REQ-020 ADD: result = a+b mod 2^WIDTH, carry = bit WIDTH of the sum. COMP: result = ~b+1, with carry set when b==0. Carry SHALL be 0 for all other ops.
REQ-021 SHRA SHALL replicate op_a[WIDTH-1]; SHLL/SHRL fill with 0; amount is never clamped (SHAMT_W bits).
REQ-022 zero = (result==0); sign = result[WIDTH-1]; both are computed for every op.
REQ-023 An undecoded control word SHALL give result=0, illegal=1, zero=1 and latency 1; illegal=0 for legal ops.
REQ-024 in_valid while BUSY/DONE SHALL be back-pressured, not queued.

Reset
REQ-025 rst low SHALL asynchronously force state=IDLE, result=0, carry=zero=sign=illegal=0, count=0 and out_valid=0; in_ready=1 from the first clock after release.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abort the operation with no output.

Configuration
REQ-027 Macro ALU_EXEC_FAST_SHIFT_EN defined: shifts use a combinational barrel shifter, never enter BUSY, and have latency 1.
REQ-028 Macro undefined: iterative shifting per REQ-017. DIFF is iterative in both builds.

Structure
REQ-029 Package alu_pkg SHALL hold the CTL_* control encodings (ADD, COMP, AND, XOR, SHLL, SHRL, SHRA, DIFF, PASSB), the FSM state typedef, and WIDTH/SHAMT_W defaults shared with alucontrol.
REQ-030 Sub-module alu_shift_step SHALL implement a one-bit shift (left, logical right, arithmetic right); the top instantiates it once.

Verification
REQ-031 ADD a=0xFFFFFFFF, b=1 -> result 0, carry 1, zero 1; out_valid 1 cycle after accept.
REQ-032 SHRA a=0x80000000, b=4 -> result 0xF8000000, sign 1; out_valid 5 cycles after accept (1 cycle with FAST_SHIFT_EN); in_ready 0 throughout.
REQ-033 DIFF a=0x10, b=0x30 -> result 5 after scan; DIFF a=b=0x1234 -> result 32.
REQ-034 Hold out_ready=0 for 10 cycles after XOR a=0xF0F0, b=0xFF00 -> result 0x0FF0 stable; in_ready 0; accept resumes the cycle after out_ready=1.
REQ-035 Assert rst during SHLL b=20 at BUSY cycle 3 -> out_valid 0, in_ready 1 after release, no stale result.
REQ-036 control 6'h3F -> illegal 1, result 0, latency 1.
